bird_motion_ctrl: RTL and testbench



---
 rtl/bird_motion_ctrl.sv | 146 ++++++++++++++
 tb/tb_bird_motion_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bird_motion_ctrl.sv
// Flappy-bird motion controller: start/rise/fall/stop/draw sequencing plus the
// per-frame velocity/position update, with a draw handshake after every move.
//
// state     | meaning
// S_START   | waiting for the first flap
// S_RISING  | alive, velocity > 0, waiting for frame_tick
// S_FALLING | alive, velocity <= 0, waiting for frame_tick
// S_STOP    | dead, waiting for a flap to restart
// S_DRAW    | draw_req high until draw_done, then go to after_draw
module bird_motion_ctrl #(
  parameter int Y_W      = 7,
  parameter int V_W      = 5,
  parameter int Y_TOP    = 0,
  parameter int Y_BOTTOM = 112,
  parameter int Y_START  = 56,
  parameter int FLAP_V   = 6,
  parameter int GRAVITY  = 1,
  parameter int V_MAX    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  flap,
  input  logic                  touched,
  input  logic                  draw_done,
  output logic                  draw_req,
  output logic [Y_W-1:0]        bird_y,
  output logic signed [V_W-1:0] velocity,
  output logic [2:0]            state,
  output logic                  dead
);

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_RISING  = 3'd1,
    S_FALLING = 3'd2,
    S_STOP    = 3'd3,
    S_DRAW    = 3'd4
  } state_e;

  localparam int YW2 = Y_W + 2;
  localparam int VW2 = V_W + 2;
  localparam logic signed [YW2-1:0] Y_TOP_S = YW2'(Y_TOP);
  localparam logic signed [YW2-1:0] Y_BOT_S = YW2'(Y_BOTTOM);
  localparam logic signed [VW2-1:0] V_FLOOR = -(VW2'(V_MAX));
  localparam logic signed [VW2-1:0] GRAV_S  = VW2'(GRAVITY);
  localparam logic signed [V_W-1:0] V_FLAP  = V_W'(FLAP_V);
  localparam logic [Y_W-1:0]        Y_RST   = Y_W'(Y_START);

  state_e                state_q, state_d, after_q, after_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic signed [V_W-1:0] v_q, v_d;
  logic                  fp_q, fp_d;

  logic                  flap_any;
  logic signed [V_W-1:0] v_sel, v_new;
  logic signed [YW2-1:0] y_n;
  logic signed [VW2-1:0] v_dec, v_sat;

  // Physics datapath, widened so neither the position nor the velocity wraps.
  always_comb begin
    flap_any = flap | fp_q;
    v_sel    = flap_any ? V_FLAP : v_q;
    y_n      = $signed({2'b00, y_q}) - YW2'(v_sel);
    v_dec    = VW2'(v_sel) - GRAV_S;
    v_sat    = (v_dec < V_FLOOR) ? V_FLOOR : v_dec;
    v_new    = flap_any ? V_FLAP : V_W'(v_sat);
  end

  always_comb begin
    state_d = state_q;
    after_d = after_q;
    y_d     = y_q;
    v_d     = v_q;
    fp_d    = fp_q | flap;
    case (state_q)
      S_START: begin
        if (flap_any) begin
          v_d     = V_FLAP;
          after_d = S_RISING;
          state_d = S_DRAW;
          fp_d    = 1'b0;
        end
      end
      S_RISING, S_FALLING: begin
        if (frame_tick) begin
          state_d = S_DRAW;
          if (touched) begin
            after_d = S_STOP;
          end else begin
            fp_d = 1'b0;
            if (y_n <= Y_TOP_S) begin
              y_d     = Y_W'(Y_TOP);
              v_d     = '0;
              after_d = S_FALLING;
            end else if (y_n >= Y_BOT_S) begin
              y_d     = Y_W'(Y_BOTTOM);
              v_d     = '0;
              after_d = S_STOP;
            end else begin
              y_d     = Y_W'(y_n);
              v_d     = v_new;
              after_d = (v_new > 0) ? S_RISING : S_FALLING;
            end
          end
        end
      end
      S_STOP: begin
        if (flap_any) begin
          y_d     = Y_RST;
          v_d     = '0;
          after_d = S_START;
          state_d = S_DRAW;
          fp_d    = 1'b0;
        end
      end
      S_DRAW: begin
        if (draw_done) state_d = after_q;
      end
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_START;
      after_q <= S_START;
      y_q     <= Y_RST;
      v_q     <= '0;
      fp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      after_q <= after_d;
      y_q     <= y_d;
      v_q     <= v_d;
      fp_q    <= fp_d;
    end
  end

  assign state    = state_q;
  assign bird_y   = y_q;
  assign velocity = v_q;
  assign draw_req = (state_q == S_DRAW);
  assign dead     = (state_q == S_STOP);

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Bench for bird_motion_ctrl: two instances (Y_START=56 and Y_START=4) share
// stimulus and are compared every cycle against a game-rule model.
module tb_bird_motion_ctrl;

  logic clk = 1'b0;
  logic reset, frame_tick, flap, touched, draw_done;
  logic dr_a, dead_a, dr_b, dead_b;
  logic [6:0] y_a, y_b;
  logic signed [4:0] v_a, v_b;
  logic [2:0] st_a, st_b;

  always #5 clk = ~clk;

  bird_motion_ctrl dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .flap(flap),
    .touched(touched), .draw_done(draw_done), .draw_req(dr_a),
    .bird_y(y_a), .velocity(v_a), .state(st_a), .dead(dead_a));

  bird_motion_ctrl #(.Y_START(4)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .flap(flap),
    .touched(touched), .draw_done(draw_done), .draw_req(dr_b),
    .bird_y(y_b), .velocity(v_b), .state(st_b), .dead(dead_b));

  // Game mode: 0 start, 1 rising, 2 falling, 3 stopped, 4 drawing
  typedef struct {
    int st;
    int ad;
    int y;
    int v;
    bit fp;
  } mdl_t;

  mdl_t ma, mb;
  int n_tests = 0;
  int n_fail  = 0;
  int yr[6]  = '{50, 45, 41, 38, 36, 35};
  int yf[10] = '{35, 36, 38, 41, 45, 50, 56, 63, 71, 79};
  int vf[10] = '{-1, -2, -3, -4, -5, -6, -7, -8, -8, -8};

  function automatic mdl_t m_reset(int ys);
    mdl_t r;
    r.st = 0; r.ad = 0; r.y = ys; r.v = 0; r.fp = 1'b0;
    return r;
  endfunction

  function automatic mdl_t m_step(mdl_t m, bit fl, bit tk, bit to, bit dn, int ys);
    mdl_t n;
    bit f;
    int vv, yn, nv;
    n = m;
    f = fl | m.fp;
    n.fp = f;
    case (m.st)
      0: if (f) begin
        n.st = 4; n.ad = 1; n.v = 6; n.fp = 1'b0;
      end
      1, 2: if (tk) begin
        n.st = 4;
        if (to) n.ad = 3;
        else begin
          n.fp = 1'b0;
          vv = f ? 6 : m.v;
          yn = m.y - vv;
          nv = f ? 6 : ((vv - 1 < -8) ? -8 : vv - 1);
          if (yn <= 0) begin
            n.y = 0; n.v = 0; n.ad = 2;
          end else if (yn >= 112) begin
            n.y = 112; n.v = 0; n.ad = 3;
          end else begin
            n.y = yn; n.v = nv; n.ad = (nv > 0) ? 1 : 2;
          end
        end
      end
      3: if (f) begin
        n.st = 4; n.ad = 0; n.y = ys; n.v = 0; n.fp = 1'b0;
      end
      4: if (dn) n.st = m.ad;
      default: n.st = 0;
    endcase
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("a_state", int'(st_a), ma.st);
    chk("a_bird_y", int'(y_a), ma.y);
    chk("a_velocity", int'(v_a), ma.v);
    chk("a_draw_req", int'(dr_a), int'(ma.st == 4));
    chk("a_dead", int'(dead_a), int'(ma.st == 3));
    chk("b_state", int'(st_b), mb.st);
    chk("b_bird_y", int'(y_b), mb.y);
    chk("b_velocity", int'(v_b), mb.v);
    chk("b_draw_req", int'(dr_b), int'(mb.st == 4));
    chk("b_dead", int'(dead_b), int'(mb.st == 3));
  endtask

  // Drive one cycle of inputs (called at negedge), step the model, compare.
  task automatic cyc(input bit fl, input bit tk, input bit to, input bit dn);
    flap = fl; frame_tick = tk; touched = to; draw_done = dn;
    @(posedge clk);
    ma = m_step(ma, fl, tk, to, dn, 56);
    mb = m_step(mb, fl, tk, to, dn, 4);
    @(negedge clk);
    chk_all();
  endtask

  task automatic apply_reset();
    flap = 1'b0; frame_tick = 1'b0; touched = 1'b0; draw_done = 1'b0;
    reset = 1'b1;
    #1;
    ma = m_reset(56);
    mb = m_reset(4);
    chk_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flap = 1'b0; frame_tick = 1'b0; touched = 1'b0; draw_done = 1'b0;
    #2;
    apply_reset();
    chk("t1_reset_y", int'(y_a), 56);
    chk("t1_reset_state", int'(st_a), 0);

    cyc(1, 0, 0, 0);
    chk("t1_flap_state", int'(st_a), 4);
    chk("t1_flap_req", int'(dr_a), 1);
    chk("t1_flap_v", int'(v_a), 6);
    chk("t1_flap_y", int'(y_a), 56);
    cyc(0, 0, 0, 1);
    chk("t1_rising", int'(st_a), 1);

    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 0);
      chk("t2_rise_y", int'(y_a), yr[i]);
      chk("t2_rise_v", int'(v_a), 5 - i);
      if (i == 0) begin
        chk("t4_ceiling_y", int'(y_b), 0);
        chk("t4_ceiling_v", int'(v_b), 0);
      end
      cyc(0, 0, 0, 1);
      if (i == 0) chk("t4_ceiling_state", int'(st_b), 2);
    end
    chk("t2_falling", int'(st_a), 2);

    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0);
      chk("t3_fall_y", int'(y_a), yf[i]);
      chk("t3_fall_v", int'(v_a), vf[i]);
      cyc(0, 0, 0, 1);
    end

    for (int k = 0; k < 40 && st_a != 3'd3; k++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 1);
    end
    chk("t4_floor_dead", int'(dead_a), 1);
    chk("t4_floor_y", int'(y_a), 112);
    chk("t4_floor_state", int'(st_a), 3);
    cyc(1, 0, 0, 0);
    chk("t4_restart_y", int'(y_a), 56);
    chk("t4_restart_v", int'(v_a), 0);
    cyc(0, 0, 0, 1);
    chk("t4_restart_state", int'(st_a), 0);

    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 1, 0);
    chk("t5_touch_y", int'(y_a), 56);
    chk("t5_touch_state", int'(st_a), 4);
    cyc(0, 0, 0, 1);
    chk("t5_touch_stop", int'(st_a), 3);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("t5_pending_restart", int'(st_a), 0);

    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    chk("t5_tick_v", int'(v_a), 5);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    chk("t5_latched_v", int'(v_a), 6);
    chk("t5_latched_y", int'(y_a), 44);

    for (int k = 0; k < 20; k++) begin
      cyc(0, (k == 3 || k == 9 || k == 15), 0, 0);
      chk("t6_stall_state", int'(st_a), 4);
      chk("t6_stall_y", int'(y_a), 44);
      chk("t6_stall_req", int'(dr_a), 1);
    end
    apply_reset();
    chk("t6_reset_req", int'(dr_a), 0);
    chk("t6_reset_state", int'(st_a), 0);
    chk("t6_reset_y", int'(y_a), 56);

    for (int k = 0; k < 5000; k++) begin
      if ($urandom_range(0, 299) == 0) apply_reset();
      else cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
